obi_sram_shim: RTL and testbench

Terminating OBI subordinate that sits directly downstream of the manager port of the OBI rready converter and maps OBI transactions onto a single-port SRAM macro with fixed read latency. It relies on the upstream converter driving rready constantly high, so it has no response back-pressure and delivers every response exactly SramLatency cycles after the request handshake. Out-of-range accesses are answered in order with an error response, without touching the SRAM.

---
 rtl/obi_sram_shim.sv | 148 ++++++++++++++
 tb/tb_obi_sram_shim.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_shim.sv
// obi_sram_shim: terminating OBI subordinate in front of a single-port SRAM
// macro with fixed read latency. Responses are never back-pressured, so a
// plain shift pipeline of SramLatency stages tracks every accepted request
// and lines it up with the SRAM read data. Out-of-range requests bypass the
// SRAM but still occupy a pipeline slot, which keeps responses in order.

package obi_sram_shim_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [0:0]  aid;
   } obi_a_chan_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
      logic        r_optional;
   } obi_r_chan_t;

endpackage

module obi_sram_shim #(
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned IdWidth     = 1,
   parameter int unsigned NumWords    = 1024,
   parameter int unsigned SramLatency = 1,
   parameter type obi_a_chan_t = obi_sram_shim_pkg::obi_a_chan_t,
   parameter type obi_r_chan_t = obi_sram_shim_pkg::obi_r_chan_t,
   localparam int unsigned SramAw    = $clog2(NumWords),
   localparam int unsigned BeWidth   = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  obi_a_chan_t          sbr_a_chan_i,
   input  logic                 req_i,
   output logic                 gnt_o,
   output obi_r_chan_t          sbr_r_chan_o,
   output logic                 rvalid_o,
   output logic                 sram_req_o,
   input  logic                 sram_gnt_i,
   output logic                 sram_we_o,
   output logic [SramAw-1:0]    sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   localparam int unsigned AddrLsb = $clog2(BeWidth);
   localparam logic [AddrWidth-1:0] LsbMask = AddrWidth'((64'd1 << AddrLsb) - 64'd1);

   logic [AddrWidth-1:0] word;
   logic                 oor;
   logic                 accept;
   logic                 unused_addr_lsb;

   // Pipeline stage state: {valid, rid, err, we} per stage, stage 0 is youngest
   logic [SramLatency-1:0]              valid_q, valid_d;
   logic [SramLatency-1:0][IdWidth-1:0] rid_q,   rid_d;
   logic [SramLatency-1:0]              err_q,   err_d;
   logic [SramLatency-1:0]              we_q,    we_d;

   logic              out_valid;
   logic [IdWidth-1:0] out_rid;
   logic              out_err;
   logic              out_we;

   // Address decode: byte address to word index plus range check
   always_comb begin
      word = sbr_a_chan_i.addr >> AddrLsb;
      oor  = (64'(word) >= 64'(NumWords));
   end

   // Byte-offset bits carry no information for a word-wide SRAM
   assign unused_addr_lsb = ^(sbr_a_chan_i.addr & LsbMask);

   // Request path: out-of-range requests are granted without touching the SRAM
   always_comb begin
      sram_req_o   = req_i & ~oor;
      gnt_o        = req_i & (oor | sram_gnt_i);
      accept       = req_i & gnt_o;
      sram_we_o    = sbr_a_chan_i.we;
      sram_addr_o  = word[SramAw-1:0];
      sram_wdata_o = sbr_a_chan_i.wdata;
      sram_be_o    = sbr_a_chan_i.be;
   end

   // Next-state of the response pipeline; it advances unconditionally
   always_comb begin
      valid_d    = valid_q;
      rid_d      = rid_q;
      err_d      = err_q;
      we_d       = we_q;
      valid_d[0] = accept;
      rid_d[0]   = sbr_a_chan_i.aid;
      err_d[0]   = oor;
      we_d[0]    = sbr_a_chan_i.we;
      for (int i = 1; i < int'(SramLatency); i++) begin
         valid_d[i] = valid_q[i-1];
         rid_d[i]   = rid_q[i-1];
         err_d[i]   = err_q[i-1];
         we_d[i]    = we_q[i-1];
      end
   end

   // Pipeline registers; reset drops anything still in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         rid_q   <= '0;
         err_q   <= '0;
         we_q    <= '0;
      end else begin
         valid_q <= valid_d;
         rid_q   <= rid_d;
         err_q   <= err_d;
         we_q    <= we_d;
      end
   end

   // Response from the oldest stage; rdata is only forwarded for good reads
   always_comb begin
      out_valid          = valid_q[SramLatency-1];
      out_rid            = rid_q[SramLatency-1];
      out_err            = err_q[SramLatency-1];
      out_we             = we_q[SramLatency-1];
      rvalid_o           = out_valid;
      sbr_r_chan_o       = '0;
      sbr_r_chan_o.rid   = out_rid;
      sbr_r_chan_o.err   = out_err;
      sbr_r_chan_o.rdata = (out_valid & ~out_we & ~out_err) ? sram_rdata_i : '0;
   end

   // A stalled request must hold its payload until it is granted
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i && !gnt_o) |=> (req_i && $stable(sbr_a_chan_i)));

   if (SramLatency == 1) begin : g_inflight_chk
      // Single-stage pipeline can never hold more than one response
      assert property (@(posedge clk_i) disable iff (!rst_ni)
         $countones(valid_q) <= SramLatency);
   end

endmodule

// File: tb/tb_obi_sram_shim.sv
// Directed bench for obi_sram_shim: three instances at SramLatency 1, 3 and 4,
// each with a behavioural SRAM model of matching latency.
module tb_obi_sram_shim;
   import obi_sram_shim_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   obi_a_chan_t a_chan    [3];
   obi_r_chan_t r_chan    [3];
   logic        req       [3];
   logic        gnt       [3];
   logic        rvalid    [3];
   logic        sram_req  [3];
   logic        sram_gnt  [3];
   logic        sram_we   [3];
   logic [9:0]  sram_addr [3];
   logic [31:0] sram_wdata[3];
   logic [3:0]  sram_be   [3];
   logic [31:0] sram_rdata[3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

      obi_sram_shim #(.SramLatency(L)) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .sbr_a_chan_i(a_chan[g]),
         .req_i       (req[g]),
         .gnt_o       (gnt[g]),
         .sbr_r_chan_o(r_chan[g]),
         .rvalid_o    (rvalid[g]),
         .sram_req_o  (sram_req[g]),
         .sram_gnt_i  (sram_gnt[g]),
         .sram_we_o   (sram_we[g]),
         .sram_addr_o (sram_addr[g]),
         .sram_wdata_o(sram_wdata[g]),
         .sram_be_o   (sram_be[g]),
         .sram_rdata_i(sram_rdata[g])
      );

      logic [31:0] mem  [1024];
      logic [31:0] pipe [L];

      // SRAM model: byte-masked writes, reads delayed by L cycles; junk otherwise
      always @(posedge clk) begin
         if (sram_req[g] && sram_gnt[g]) begin
            if (sram_we[g]) begin
               for (int b = 0; b < 4; b++)
                  if (sram_be[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
               pipe[0] <= 32'h5A5A_5A5A;
            end else begin
               pipe[0] <= mem[sram_addr[g]];
            end
         end else begin
            pipe[0] <= 32'hA5A5_A5A5;
         end
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign sram_rdata[g] = pipe[L-1];
   end

   // Drive one cycle on instance k at the negedge, then let outputs settle
   task automatic step(input int k, input logic r, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] b, input logic id);
      @(negedge clk);
      for (int j = 0; j < 3; j++) req[j] = 1'b0;
      req[k]          = r;
      a_chan[k].addr  = ad;
      a_chan[k].we    = w;
      a_chan[k].wdata = wd;
      a_chan[k].be    = b;
      a_chan[k].aid   = id;
      #1;
   endtask

   task automatic idle(input int k);
      step(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   task automatic test_reset;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rvalid[k] !== 1'b0 || r_chan[k] !== '0) begin
            errors++;
            $display("FAIL reset_outputs inst %0d: rvalid %b r_chan %h, required 0 and 0", k, rvalid[k], r_chan[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_raw;
      step(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
      checks++;
      if (gnt[0] !== 1'b1 || sram_req[0] !== 1'b1 || sram_addr[0] !== 10'd4) begin
         errors++;
         $display("FAIL raw_write_req: gnt %b sram_req %b addr %0d, required 1 1 4", gnt[0], sram_req[0], sram_addr[0]);
      end
      step(0, 1, 0, 32'h10, 32'h0, 4'hF, 1'b0);
      checks++;
      if (rvalid[0] !== 1'b1 || r_chan[0].rid !== 1'b1 || r_chan[0].err !== 1'b0 || r_chan[0].rdata !== 32'h0) begin
         errors++;
         $display("FAIL raw_write_rsp: rvalid %b rid %b err %b rdata %h, required 1 1 0 0", rvalid[0], r_chan[0].rid, r_chan[0].err, r_chan[0].rdata);
      end
      idle(0);
      checks++;
      if (rvalid[0] !== 1'b1 || r_chan[0].rid !== 1'b0 || r_chan[0].err !== 1'b0 || r_chan[0].rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL raw_read_rsp: rvalid %b rid %b err %b rdata %h, required 1 0 0 deadbeef", rvalid[0], r_chan[0].rid, r_chan[0].err, r_chan[0].rdata);
      end
      idle(0);
      checks++;
      if (rvalid[0] !== 1'b0) begin
         errors++;
         $display("FAIL raw_single_pulse: rvalid %b, required 0", rvalid[0]);
      end
   endtask

   task automatic test_oor;
      sram_gnt[0] = 1'b0;
      step(0, 1, 0, 32'h1000, 32'h0, 4'hF, 1'b1);
      checks++;
      if (gnt[0] !== 1'b1 || sram_req[0] !== 1'b0) begin
         errors++;
         $display("FAIL oor_grant: gnt %b sram_req %b, required 1 0", gnt[0], sram_req[0]);
      end
      sram_gnt[0] = 1'b1;
      step(0, 1, 0, 32'h10, 32'h0, 4'hF, 1'b0);
      checks++;
      if (rvalid[0] !== 1'b1 || r_chan[0].err !== 1'b1 || r_chan[0].rid !== 1'b1 || r_chan[0].rdata !== 32'h0) begin
         errors++;
         $display("FAIL oor_rsp: rvalid %b err %b rid %b rdata %h, required 1 1 1 0", rvalid[0], r_chan[0].err, r_chan[0].rid, r_chan[0].rdata);
      end
      step(0, 1, 0, 32'h2000, 32'h0, 4'hF, 1'b1);
      checks++;
      if (rvalid[0] !== 1'b1 || r_chan[0].err !== 1'b0 || r_chan[0].rid !== 1'b0 || r_chan[0].rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL order_inrange_rsp: rvalid %b err %b rid %b rdata %h, required 1 0 0 deadbeef", rvalid[0], r_chan[0].err, r_chan[0].rid, r_chan[0].rdata);
      end
      idle(0);
      checks++;
      if (rvalid[0] !== 1'b1 || r_chan[0].err !== 1'b1 || r_chan[0].rid !== 1'b1 || r_chan[0].rdata !== 32'h0) begin
         errors++;
         $display("FAIL order_oor_rsp: rvalid %b err %b rid %b rdata %h, required 1 1 1 0", rvalid[0], r_chan[0].err, r_chan[0].rid, r_chan[0].rdata);
      end
      idle(0);
   endtask

   task automatic test_partial_write;
      step(0, 1, 1, 32'h14, 32'hFFFF_FFFF, 4'hF, 1'b0);
      step(0, 1, 1, 32'h14, 32'h0000_0000, 4'h5, 1'b0);
      step(0, 1, 1, 32'h14, 32'h0000_0000, 4'h0, 1'b1);
      step(0, 1, 0, 32'h14, 32'h0, 4'hF, 1'b0);
      checks++;
      if (rvalid[0] !== 1'b1 || r_chan[0].err !== 1'b0 || r_chan[0].rid !== 1'b1) begin
         errors++;
         $display("FAIL be_zero_rsp: rvalid %b err %b rid %b, required 1 0 1", rvalid[0], r_chan[0].err, r_chan[0].rid);
      end
      idle(0);
      checks++;
      if (rvalid[0] !== 1'b1 || r_chan[0].rdata !== 32'hFF00_FF00) begin
         errors++;
         $display("FAIL partial_write: rvalid %b rdata %h, required 1 ff00ff00", rvalid[0], r_chan[0].rdata);
      end
      idle(0);
   endtask

   task automatic test_contention;
      sram_gnt[0] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step(0, 1, 0, 32'h10, 32'h0, 4'hF, 1'b1);
         checks++;
         if (gnt[0] !== 1'b0 || rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL contention_stall cycle %0d: gnt %b rvalid %b, required 0 0", c, gnt[0], rvalid[0]);
         end
      end
      sram_gnt[0] = 1'b1;
      #1;
      checks++;
      if (gnt[0] !== 1'b1) begin
         errors++;
         $display("FAIL contention_grant: gnt %b, required 1", gnt[0]);
      end
      idle(0);
      checks++;
      if (rvalid[0] !== 1'b1 || r_chan[0].rid !== 1'b1 || r_chan[0].rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL contention_rsp: rvalid %b rid %b rdata %h, required 1 1 deadbeef", rvalid[0], r_chan[0].rid, r_chan[0].rdata);
      end
      idle(0);
   endtask

   task automatic test_back_to_back;
      for (int pass = 0; pass < 2; pass++) begin
         for (int c = 0; c < 20; c++) begin
            if (c < 16)
               step(1, 1, (pass == 0), 32'(c * 4), {16'hC0DE, 16'(c)}, 4'hF, 1'(c % 2));
            else
               idle(1);
            if (c < 16) begin
               checks++;
               if (gnt[1] !== 1'b1) begin
                  errors++;
                  $display("FAIL stream_gnt pass %0d cycle %0d: gnt %b, required 1", pass, c, gnt[1]);
               end
            end
            if (c >= 3 && c < 19) begin
               checks++;
               if (rvalid[1] !== 1'b1 || r_chan[1].rid !== 1'((c - 3) % 2) || r_chan[1].err !== 1'b0 ||
                   r_chan[1].rdata !== ((pass == 0) ? 32'h0 : {16'hC0DE, 16'(c - 3)})) begin
                  errors++;
                  $display("FAIL stream_rsp pass %0d cycle %0d: rvalid %b rid %b err %b rdata %h, required 1 %0d 0 %h",
                           pass, c, rvalid[1], r_chan[1].rid, r_chan[1].err, r_chan[1].rdata, (c - 3) % 2,
                           (pass == 0) ? 32'h0 : {16'hC0DE, 16'(c - 3)});
               end
            end else begin
               checks++;
               if (rvalid[1] !== 1'b0) begin
                  errors++;
                  $display("FAIL stream_idle pass %0d cycle %0d: rvalid %b, required 0", pass, c, rvalid[1]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_midflight;
      step(2, 1, 1, 32'h1C, 32'h1234_5678, 4'hF, 1'b0);
      for (int c = 0; c < 5; c++) idle(2);
      step(2, 1, 0, 32'h1C, 32'h0, 4'hF, 1'b1);
      checks++;
      if (gnt[2] !== 1'b1) begin
         errors++;
         $display("FAIL midflight_gnt: gnt %b, required 1", gnt[2]);
      end
      idle(2);
      idle(2);
      rst_n = 1'b0;
      #1;
      checks++;
      if (rvalid[2] !== 1'b0 || r_chan[2] !== '0) begin
         errors++;
         $display("FAIL midflight_reset_out: rvalid %b r_chan %h, required 0 0", rvalid[2], r_chan[2]);
      end
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         idle(2);
         checks++;
         if (rvalid[2] !== 1'b0) begin
            errors++;
            $display("FAIL midflight_dropped cycle %0d: rvalid %b, required 0", c, rvalid[2]);
         end
      end
      step(2, 1, 0, 32'h1C, 32'h0, 4'hF, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         idle(2);
         checks++;
         if (c < 4) begin
            if (rvalid[2] !== 1'b0) begin
               errors++;
               $display("FAIL post_reset_early cycle %0d: rvalid %b, required 0", c, rvalid[2]);
            end
         end else if (rvalid[2] !== 1'b1 || r_chan[2].rid !== 1'b0 || r_chan[2].rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL post_reset_read: rvalid %b rid %b rdata %h, required 1 0 12345678", rvalid[2], r_chan[2].rid, r_chan[2].rdata);
         end
      end
      idle(2);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         req[k]      = 1'b0;
         sram_gnt[k] = 1'b1;
         a_chan[k]   = '0;
      end
      test_reset;
      test_raw;
      test_oor;
      test_partial_write;
      test_contention;
      test_back_to_back;
      test_reset_midflight;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
